// File: rtl/video_timing_gen.sv
// Pixel-clock raster timing generator: signed sx/sy counters plus registered
// sync, enable, strobe and frame-count outputs, all aligned to the same (sx,sy).
module video_timing_gen #(
    parameter int COORDSPC = 16,
    parameter int H_RES    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_RES    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int FRAMEW   = 16
) (
    input  logic                       video_clk_pix,
    input  logic                       reset,
    output logic signed [COORDSPC-1:0] sx,
    output logic signed [COORDSPC-1:0] sy,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       video_enable,
    output logic                       line_start,
    output logic                       frame_start,
    output logic [FRAMEW-1:0]          frame_count
);

    localparam logic signed [COORDSPC-1:0] H_STA   = COORDSPC'(-(H_FP + H_SYNC + H_BP));
    localparam logic signed [COORDSPC-1:0] HS_STA  = COORDSPC'(-(H_SYNC + H_BP));
    localparam logic signed [COORDSPC-1:0] HS_END  = COORDSPC'(-H_BP - 1);
    localparam logic signed [COORDSPC-1:0] H_LAST  = COORDSPC'(H_RES - 1);
    localparam logic signed [COORDSPC-1:0] V_STA   = COORDSPC'(-(V_FP + V_SYNC + V_BP));
    localparam logic signed [COORDSPC-1:0] VS_STA  = COORDSPC'(-(V_SYNC + V_BP));
    localparam logic signed [COORDSPC-1:0] VS_END  = COORDSPC'(-V_BP - 1);
    localparam logic signed [COORDSPC-1:0] V_LAST  = COORDSPC'(V_RES - 1);
    localparam logic signed [COORDSPC-1:0] C_ZERO  = COORDSPC'(0);
    localparam logic signed [COORDSPC-1:0] C_ONE   = COORDSPC'(1);
    localparam logic                       H_ACT   = 1'(H_POL);
    localparam logic                       V_ACT   = 1'(V_POL);

    function automatic logic in_span(input logic signed [COORDSPC-1:0] v,
                                     input logic signed [COORDSPC-1:0] lo,
                                     input logic signed [COORDSPC-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic signed [COORDSPC-1:0] sx_p0, sy_p0;
    logic                       hsync_p0, vsync_p0, de_p0, ls_p0, fs_p0;

    logic signed [COORDSPC-1:0] sx_p1, sy_p1;
    logic                       hsync_p1, vsync_p1, de_p1, ls_p1, fs_p1;
    logic [FRAMEW-1:0]          fc_p1;

    // Stage p0: next raster position and the flags describing that position
    always_comb begin
        sx_p0 = sx_p1 + C_ONE;
        sy_p0 = sy_p1;
        if (sx_p1 == H_LAST) begin
            sx_p0 = H_STA;
            sy_p0 = (sy_p1 == V_LAST) ? V_STA : sy_p1 + C_ONE;
        end
        hsync_p0 = in_span(sx_p0, HS_STA, HS_END) ? H_ACT : ~H_ACT;
        vsync_p0 = in_span(sy_p0, VS_STA, VS_END) ? V_ACT : ~V_ACT;
        de_p0    = (sx_p0 >= C_ZERO) && (sy_p0 >= C_ZERO);
        ls_p0    = (sx_p0 == H_STA);
        fs_p0    = (sx_p0 == H_STA) && (sy_p0 == V_STA);
    end

    // Stage p1: every output registered together so they describe the same pixel
    always_ff @(posedge video_clk_pix) begin
        if (reset) begin
            sx_p1    <= H_LAST;
            sy_p1    <= V_LAST;
            hsync_p1 <= ~H_ACT;
            vsync_p1 <= ~V_ACT;
            de_p1    <= 1'b0;
            ls_p1    <= 1'b0;
            fs_p1    <= 1'b0;
            fc_p1    <= '1;
        end else begin
            sx_p1    <= sx_p0;
            sy_p1    <= sy_p0;
            hsync_p1 <= hsync_p0;
            vsync_p1 <= vsync_p0;
            de_p1    <= de_p0;
            ls_p1    <= ls_p0;
            fs_p1    <= fs_p0;
            if (fs_p0) fc_p1 <= fc_p1 + FRAMEW'(1);
        end
    end

    assign sx           = sx_p1;
    assign sy           = sy_p1;
    assign hsync        = hsync_p1;
    assign vsync        = vsync_p1;
    assign video_enable = de_p1;
    assign line_start   = ls_p1;
    assign frame_start  = fs_p1;
    assign frame_count  = fc_p1;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 instance for line/vsync/reset behaviour and a
// tiny positive-polarity instance with 2-bit frame counter for frame-level timing.
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic signed [15:0] a_sx, a_sy, b_sx, b_sy;
    logic a_hs, a_vs, a_en, a_ls, a_fs, b_hs, b_vs, b_en, b_ls, b_fs;
    logic [15:0] a_fc;
    logic [1:0]  b_fc;

    video_timing_gen dut_a (
        .video_clk_pix(clk), .reset(rst_a), .sx(a_sx), .sy(a_sy),
        .hsync(a_hs), .vsync(a_vs), .video_enable(a_en),
        .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
    );

    video_timing_gen #(
        .H_RES(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(1), .FRAMEW(2)
    ) dut_b (
        .video_clk_pix(clk), .reset(rst_b), .sx(b_sx), .sy(b_sy),
        .hsync(b_hs), .vsync(b_vs), .video_enable(b_en),
        .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int ex, ey, bad, hl, hfirst, lsn, ls2, en, vl, vfx, vfy, fsn;
    int hh, vh, efc, fsi_last, prev_ls, prev_fs;
    int fcs [5];

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (5) step();

        // default instance, reset state
        chk("a_rst_sx", a_sx, 639);
        chk("a_rst_sy", a_sy, 479);
        chk("a_rst_hsync", a_hs, 1);
        chk("a_rst_vsync", a_vs, 1);
        chk("a_rst_en", a_en, 0);
        chk("a_rst_ls", a_ls, 0);
        chk("a_rst_fs", a_fs, 0);
        chk("a_rst_fc", a_fc, 65535);

        rst_a = 1'b0;
        step();
        chk("a_rel_sx", a_sx, -160);
        chk("a_rel_sy", a_sy, -45);
        chk("a_rel_fs", a_fs, 1);
        chk("a_rel_ls", a_ls, 1);
        chk("a_rel_fc", a_fc, 0);

        // 47 lines: sy -45..1 covers vsync lines and two active lines
        ex = -160; ey = -45; bad = 0; hl = 0; hfirst = 9999; lsn = 0; ls2 = -1;
        en = 0; vl = 0; vfx = 9999; vfy = 9999; fsn = 0;
        for (int i = 0; i < 37600; i++) begin
            if ((a_sx !== 16'(ex)) || (a_sy !== 16'(ey))) bad++;
            if (a_hs !== !(ex >= -144 && ex <= -49)) bad++;
            if (a_en !== (ex >= 0 && ey >= 0)) bad++;
            if (a_fc !== 16'd0) bad++;
            if (a_hs === 1'b0 && ey == -45) begin
                if (hl == 0) hfirst = ex;
                hl++;
            end
            if (a_ls === 1'b1) begin
                lsn++;
                if (lsn == 2) ls2 = i;
            end
            if (a_en === 1'b1) en++;
            if (a_vs === 1'b0) begin
                if (vl == 0) begin vfx = ex; vfy = ey; end
                vl++;
            end
            if (a_fs === 1'b1) fsn++;
            step();
            ex++;
            if (ex == 640) begin ex = -160; ey++; end
        end
        chk("a_pos_and_flags_bad", bad, 0);
        chk("a_hsync_low_cycles", hl, 96);
        chk("a_hsync_first_sx", hfirst, -144);
        chk("a_line_start_count", lsn, 47);
        chk("a_line_start_period", ls2, 800);
        chk("a_enable_cycles", en, 1280);
        chk("a_vsync_low_cycles", vl, 1600);
        chk("a_vsync_first_sx", vfx, -160);
        chk("a_vsync_first_sy", vfy, -35);
        chk("a_frame_start_count", fsn, 1);

        // mid-frame reset during an active line
        repeat (260) step();
        chk("a_mid_sx", a_sx, 100);
        chk("a_mid_sy", a_sy, 2);
        chk("a_mid_en", a_en, 1);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk("a_mrst_sx", a_sx, 639);
        chk("a_mrst_sy", a_sy, 479);
        chk("a_mrst_ls", a_ls, 0);
        chk("a_mrst_fs", a_fs, 0);
        chk("a_mrst_fc", a_fc, 65535);
        step();
        chk("a_mrel_sx", a_sx, -160);
        chk("a_mrel_sy", a_sy, -45);
        chk("a_mrel_fs", a_fs, 1);
        chk("a_mrel_ls", a_ls, 1);
        chk("a_mrel_fc", a_fc, 0);

        // small positive-polarity instance, held in reset until now
        chk("b_rst_sx", b_sx, 7);
        chk("b_rst_sy", b_sy, 3);
        chk("b_rst_hsync", b_hs, 0);
        chk("b_rst_vsync", b_vs, 0);
        chk("b_rst_fc", b_fc, 3);
        rst_b = 1'b0;
        step();
        chk("b_rel_sx", b_sx, -4);
        chk("b_rel_sy", b_sy, -3);
        chk("b_rel_fs", b_fs, 1);
        chk("b_rel_fc", b_fc, 0);

        ex = -4; ey = -3; bad = 0; hh = 0; vh = 0; lsn = 0; en = 0; fsn = 0;
        efc = 0; fsi_last = -1; prev_ls = 0; prev_fs = 0;
        for (int i = 0; i < 420; i++) begin
            if (i > 0 && ex == -4 && ey == -3) efc = (efc + 1) % 4;
            if ((b_sx !== 16'(ex)) || (b_sy !== 16'(ey))) bad++;
            if (b_hs !== (ex >= -3 && ex <= -2)) bad++;
            if (b_vs !== (ey == -2)) bad++;
            if (b_en !== (ex >= 0 && ey >= 0)) bad++;
            if (b_ls !== (ex == -4)) bad++;
            if (b_fs !== (ex == -4 && ey == -3)) bad++;
            if (b_fc !== 2'(efc)) bad++;
            if ((b_ls === 1'b1 && prev_ls == 1) || (b_fs === 1'b1 && prev_fs == 1)) bad++;
            prev_ls = (b_ls === 1'b1) ? 1 : 0;
            prev_fs = (b_fs === 1'b1) ? 1 : 0;
            if (b_hs === 1'b1) hh++;
            if (b_vs === 1'b1) vh++;
            if (b_ls === 1'b1) lsn++;
            if (b_en === 1'b1) en++;
            if (b_fs === 1'b1) begin
                if (fsn < 5) fcs[fsn] = int'(b_fc);
                fsn++;
                fsi_last = i;
            end
            step();
            ex++;
            if (ex == 8) begin
                ex = -4;
                ey = (ey == 3) ? -3 : ey + 1;
            end
        end
        chk("b_pos_and_flags_bad", bad, 0);
        chk("b_hsync_high_cycles", hh, 70);
        chk("b_vsync_high_cycles", vh, 60);
        chk("b_line_start_count", lsn, 35);
        chk("b_enable_cycles", en, 160);
        chk("b_frame_start_count", fsn, 5);
        chk("b_last_frame_start_idx", fsi_last, 336);
        chk("b_fc_frame0", fcs[0], 0);
        chk("b_fc_frame1", fcs[1], 1);
        chk("b_fc_frame2", fcs[2], 2);
        chk("b_fc_frame3", fcs[3], 3);
        chk("b_fc_frame4", fcs[4], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Pixel-clock raster timing generator: the source of the sync, enable, strobe and signed-coordinate bus that the demo renderers (rasterbars and similar) consume.
- Counts a signed horizontal/vertical position over blanking and active regions and drives hsync, vsync, video_enable, line_start, frame_start, sx, sy and a frame counter, all registered and mutually aligned.
- Sits between the pixel clock domain and the demo/renderer stage feeding the HDMI encoder.
- Defaults give 640x480@60 (800x525 total).

Parameters:
- COORDSPC, 16: width of signed sx/sy (bits); must hold -(blanking) .. RES-1.
- H_RES, 640: active pixels per line.
- H_FP, 16: horizontal front porch (pixels).
- H_SYNC, 96: horizontal sync width (pixels).
- H_BP, 48: horizontal back porch (pixels).
- V_RES, 480: active lines per frame.
- V_FP, 10: vertical front porch (lines).
- V_SYNC, 2: vertical sync width (lines).
- V_BP, 33: vertical back porch (lines).
- H_POL, 0: hsync active level (0 = active-low).
- V_POL, 0: vsync active level (0 = active-low).
- FRAMEW, 16: frame_count width.

Ports:
- video_clk_pix  input  1  pixel clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sx  output  COORDSPC (signed)  horizontal position; H_STA .. H_RES-1.
- sy  output  COORDSPC (signed)  vertical position; V_STA .. V_RES-1.
- hsync  output  1  horizontal sync at H_POL level during sync interval.
- vsync  output  1  vertical sync at V_POL level during sync lines.
- video_enable  output  1  high when sx>=0 and sy>=0.
- line_start  output  1  one-cycle strobe at sx==H_STA, every line.
- frame_start  output  1  one-cycle strobe at sx==H_STA and sy==V_STA.
- frame_count  output  FRAMEW  frame index; increments at each frame_start.

Behaviour:
- Derived constants:
  - H_STA = -(H_FP+H_SYNC+H_BP) (default -160); V_STA = -(V_FP+V_SYNC+V_BP) (default -45).
  - Horizontal regions: front porch H_STA..H_STA+H_FP-1; sync H_STA+H_FP..H_STA+H_FP+H_SYNC-1 (default -144..-49); back porch next H_BP; active 0..H_RES-1.
  - Vertical regions are the same pattern in lines (default sync lines -35..-34).
- Counting:
  - sx increments every cycle.
  - At sx==H_RES-1, sx wraps to H_STA and sy increments.
  - At sy==V_RES-1 with sx==H_RES-1, sy wraps to V_STA.
  - Line period = H_RES-H_STA cycles (800); frame = (V_RES-V_STA) lines (525, i.e. 420000 cycles).
- Registered outputs: every output is a flop. Each cycle's hsync, vsync, video_enable, line_start, frame_start and frame_count describe exactly the (sx,sy) presented in that same cycle. Zero skew between any outputs.
- vsync asserts/deasserts on the same cycle sx==H_STA on the boundary line (line-aligned, not pixel-offset).
- frame_count:
  - Increments (mod 2^FRAMEW) on the same edge that loads (H_STA,V_STA).
  - Value is stable for the whole frame, including while frame_start is high.
- Reset, while reset is high at a clock edge:
  - sx=H_RES-1, sy=V_RES-1.
  - hsync=~H_POL, vsync=~V_POL.
  - video_enable=0, line_start=0, frame_start=0, frame_count=all ones.
- First edge with reset low:
  - Loads (H_STA,V_STA) with frame_start=1, line_start=1 and frame_count=0.
  - First displayed frame is frame 0.
- Reset asserted mid-frame: takes effect on the next edge regardless of position. There are no partial-line strobes, and the restart sequence is identical to power-up.
- Strobes:
  - line_start is high on frame_start cycles too.
  - Neither strobe is ever high for more than one consecutive cycle.
- No combinational path from any input to any output.

Test Plan:
- Reset release: hold reset 5 cycles, then deassert. During reset: sx=639, sy=479, hsync=vsync=1, video_enable=0, frame_count=16'hFFFF. First cycle after release: sx=-160, sy=-45, frame_start=1, line_start=1, frame_count=0.
- Horizontal timing over one line:
  - hsync low exactly for sx=-144..-49 (96 cycles).
  - line_start period 800 cycles.
  - video_enable low on all lines with sy<0.
- Full frame:
  - vsync low for exactly 1600 cycles, starting at sy=-35, sx=-160.
  - video_enable high for 307200 cycles.
  - frame_start period 420000.
  - frame_count 0 -> 1 -> 2 across three frames.
- Mid-frame reset: assert reset 1 cycle at sx=100, sy=200. Next cycle shows reset values; the following cycle shows sx=-160, sy=-45, frame_start=1, frame_count=0. No spurious line_start in between.
- Polarity and small-config run:
  - Parameters H_RES=8, H_FP=1, H_SYNC=2, H_BP=1, V_RES=4, V_FP=1, V_SYNC=1, V_BP=1, H_POL=V_POL=1.
  - hsync high only at sx=-3..-2; vsync high only on sy=-2.
  - Line = 12 cycles, frame = 84 cycles.
- frame_count wrap with FRAMEW=2: count sequence is 0,1,2,3,0 over five frames, each change aligned with frame_start.
